ctx_stack: RTL and testbench

- Multi-context hardware stack for the Forth core, generalising the single-pointer stack.
- One shared block RAM is partitioned into 2**CTX_BITS independent stacks, for example data and return stacks or per-task stacks.
- Each context keeps its own pointer and depth.
- Per-cycle ops are NOP/PUSH/POP/REPLACE/POP_REPLACE, with registered top (q) and next (nos) outputs, depth/full/empty status and sticky overflow/underflow errors.

---
 rtl/stack_pkg.sv | 12 +
 rtl/ctx_stack_if.sv | 33 +++
 rtl/stack_ptr_next.sv | 65 ++++++
 rtl/ctx_stack.sv | 108 ++++++++++
 tb/tb_ctx_stack.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the multi-context stack.
//   OP_W            width of the per-cycle op code
//   OP_NOP..OP_POP_REPLACE  op encodings; codes 5-7 are decoded as NOP
package stack_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP         = 3'd0;
    localparam logic [OP_W-1:0] OP_PUSH        = 3'd1;
    localparam logic [OP_W-1:0] OP_POP         = 3'd2;
    localparam logic [OP_W-1:0] OP_REPLACE     = 3'd3;
    localparam logic [OP_W-1:0] OP_POP_REPLACE = 3'd4;
endpackage

// File: rtl/ctx_stack_if.sv
// ctx_stack_if: op/data bus of the multi-context stack.
//   master: drives ctx, op, d, err_clr; receives q, nos, depth, empty, full,
//           ovf_err, udf_err
//   slave : the stack side of the same signals
interface ctx_stack_if
    import stack_pkg::*;
#(
    parameter int SADDR_WIDTH = 8,
    parameter int WIDTH       = 16,
    parameter int CTX_BITS    = 1
);
    logic [CTX_BITS-1:0]    ctx;
    logic [OP_W-1:0]        op;
    logic [WIDTH-1:0]       d;
    logic                   err_clr;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       nos;
    logic [SADDR_WIDTH-1:0] depth;
    logic                   empty;
    logic                   full;
    logic                   ovf_err;
    logic                   udf_err;

    modport master (
        output ctx, op, d, err_clr,
        input  q, nos, depth, empty, full, ovf_err, udf_err
    );

    modport slave (
        input  ctx, op, d, err_clr,
        output q, nos, depth, empty, full, ovf_err, udf_err
    );
endinterface

// File: rtl/stack_ptr_next.sv
// stack_ptr_next: combinational next-pointer / next-depth logic for one
// context.
//   sp, depth, op          current pointer, entry count, op code
//   sp_next, depth_next    state after the op
//   we                     write d at sp_next
//   ovf, udf               overflow / underflow detected for this op
// Build option: STACK_GUARD_EN suppresses erroring ops (state held, no write).
// Without it, erroring ops execute: sp wraps, depth saturates.
module stack_ptr_next
    import stack_pkg::*;
#(
    parameter int SADDR_WIDTH = 8
) (
    input  logic [SADDR_WIDTH-1:0] sp,
    input  logic [SADDR_WIDTH-1:0] depth,
    input  logic [OP_W-1:0]        op,
    output logic [SADDR_WIDTH-1:0] sp_next,
    output logic [SADDR_WIDTH-1:0] depth_next,
    output logic                   we,
    output logic                   ovf,
    output logic                   udf
);
    localparam logic [SADDR_WIDTH-1:0] DEPTH_MAX = '1;
    localparam logic [SADDR_WIDTH-1:0] ONE       = SADDR_WIDTH'(1);
    localparam logic [SADDR_WIDTH-1:0] TWO       = SADDR_WIDTH'(2);

    always_comb begin
        sp_next    = sp;
        depth_next = depth;
        we         = 1'b0;
        ovf        = 1'b0;
        udf        = 1'b0;
        case (op)
            OP_PUSH: begin
                ovf        = (depth == DEPTH_MAX);
                sp_next    = sp + ONE;
                depth_next = (depth == DEPTH_MAX) ? depth : depth + ONE;
                we         = 1'b1;
            end
            OP_POP: begin
                udf        = (depth == '0);
                sp_next    = sp - ONE;
                depth_next = (depth == '0) ? depth : depth - ONE;
            end
            OP_REPLACE: begin
                udf = (depth == '0);
                we  = 1'b1;
            end
            OP_POP_REPLACE: begin
                udf        = (depth < TWO);
                sp_next    = sp - ONE;
                depth_next = (depth == '0) ? depth : depth - ONE;
                we         = 1'b1;
            end
            default: ;
        endcase
`ifdef STACK_GUARD_EN
        if (ovf || udf) begin
            sp_next    = sp;
            depth_next = depth;
            we         = 1'b0;
        end
`endif
    end
endmodule

// File: rtl/ctx_stack.sv
// ctx_stack: one RAM partitioned into 2**CTX_BITS independent stacks.
//   clk, reset   clock and asynchronous active-high reset
//   bus (slave)  ctx/op/d/err_clr in; q, nos, depth, empty, full,
//                ovf_err, udf_err out (one cycle after the op)
// Build option: STACK_GUARD_EN (see stack_ptr_next).
// The RAM is duplicated so that top and next-of-stack read in the same cycle;
// both copies share one write port.
module ctx_stack
    import stack_pkg::*;
#(
    parameter int SADDR_WIDTH = 8,
    parameter int WIDTH       = 16,
    parameter int CTX_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    ctx_stack_if.slave bus
);
    localparam int NCTX = 2 ** CTX_BITS;
    localparam int AW   = CTX_BITS + SADDR_WIDTH;
    localparam logic [SADDR_WIDTH-1:0] DEPTH_MAX = '1;
    localparam logic [SADDR_WIDTH-1:0] ONE       = SADDR_WIDTH'(1);
    localparam logic [SADDR_WIDTH-1:0] TWO       = SADDR_WIDTH'(2);

    logic [SADDR_WIDTH-1:0] sp_reg    [NCTX];
    logic [SADDR_WIDTH-1:0] cnt_reg   [NCTX];
    logic [SADDR_WIDTH-1:0] depth_reg;
    logic                   ovf_reg;
    logic                   udf_reg;

    logic [SADDR_WIDTH-1:0] sp_next;
    logic [SADDR_WIDTH-1:0] depth_next;
    logic                   we;
    logic                   ovf;
    logic                   udf;
    logic [AW-1:0]          waddr;
    logic [AW-1:0]          raddr [2];

    stack_ptr_next #(.SADDR_WIDTH(SADDR_WIDTH)) u_ptr_next (
        .sp         (sp_reg[bus.ctx]),
        .depth      (cnt_reg[bus.ctx]),
        .op         (bus.op),
        .sp_next    (sp_next),
        .depth_next (depth_next),
        .we         (we),
        .ovf        (ovf),
        .udf        (udf)
    );

    // Writes always land on the new top, so port 0 reads the write address.
    assign waddr    = {bus.ctx, sp_next};
    assign raddr[0] = waddr;
    assign raddr[1] = {bus.ctx, sp_next - ONE};

    // Two RAM copies with write-first registered read: a read of the address
    // being written returns d rather than the stale word.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            logic [WIDTH-1:0] mem [2**AW];
            logic [WIDTH-1:0] rd_word;

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= bus.d;
                end
                if (we && (waddr == raddr[gi])) begin
                    rd_word <= bus.d;
                end else begin
                    rd_word <= mem[raddr[gi]];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCTX; c++) begin
                sp_reg[c]  <= '0;
                cnt_reg[c] <= '0;
            end
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            for (int c = 0; c < NCTX; c++) begin
                if (bus.ctx == CTX_BITS'(c)) begin
                    sp_reg[c]  <= sp_next;
                    cnt_reg[c] <= depth_next;
                end
            end
            depth_reg <= depth_next;
            // Setting wins over a simultaneous clear.
            ovf_reg   <= ovf | (ovf_reg & ~bus.err_clr);
            udf_reg   <= udf | (udf_reg & ~bus.err_clr);
        end
    end

    // Masking keys off the reset-able depth register, so q/nos read as zero
    // immediately on reset even though the RAM read registers are not reset.
    assign bus.depth   = depth_reg;
    assign bus.empty   = (depth_reg == '0);
    assign bus.full    = (depth_reg == DEPTH_MAX);
    assign bus.q       = (depth_reg == '0) ? '0 : g_ram[0].rd_word;
    assign bus.nos     = (depth_reg < TWO) ? '0 : g_ram[1].rd_word;
    assign bus.ovf_err = ovf_reg;
    assign bus.udf_err = udf_reg;
endmodule

// File: tb/tb_ctx_stack.sv
// tb_ctx_stack: directed self-checking bench for ctx_stack (default
// parameters). Expected values are hand-computed; STACK_GUARD_EN selects
// the guarded expectations.
module tb_ctx_stack;
    import stack_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    ctx_stack_if #(.SADDR_WIDTH(8), .WIDTH(16), .CTX_BITS(1)) bus ();

    ctx_stack #(.SADDR_WIDTH(8), .WIDTH(16), .CTX_BITS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one op for one clock; outputs are sampled 1 ns after the edge.
    task automatic do_op(input logic c, input logic [2:0] o, input logic [15:0] dd,
                         input logic clr = 1'b0);
        bus.ctx     = c;
        bus.op      = o;
        bus.d       = dd;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        bus.op      = OP_NOP;
        bus.err_clr = 1'b0;
    endtask

    task automatic do_reset();
        bus.ctx     = 1'b0;
        bus.op      = OP_NOP;
        bus.d       = '0;
        bus.err_clr = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        check("rst_q", bus.q, 0);
        check("rst_nos", bus.nos, 0);
        check("rst_depth", bus.depth, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_ovf", bus.ovf_err, 0);
        check("rst_udf", bus.udf_err, 0);

        // Three pushes on ctx0
        do_op(0, OP_PUSH, 16'h1111);
        check("push1_q", bus.q, 16'h1111);
        check("push1_nos", bus.nos, 0);
        do_op(0, OP_PUSH, 16'h2222);
        do_op(0, OP_PUSH, 16'h3333);
        check("push3_q", bus.q, 16'h3333);
        check("push3_nos", bus.nos, 16'h2222);
        check("push3_depth", bus.depth, 3);
        check("push3_empty", bus.empty, 0);

        // Interleaved contexts and context-switch peeks
        do_reset();
        do_op(0, OP_PUSH, 16'hAAAA);
        do_op(1, OP_PUSH, 16'hBBBB);
        check("il_push1_q", bus.q, 16'hBBBB);
        do_op(0, OP_NOP, 16'h0);
        check("peek0_q", bus.q, 16'hAAAA);
        check("peek0_depth", bus.depth, 1);
        check("peek0_nos", bus.nos, 0);
        do_op(1, OP_NOP, 16'h0);
        check("peek1_q", bus.q, 16'hBBBB);
        check("peek1_depth", bus.depth, 1);
        do_op(0, 3'd7, 16'hFFFF);
        check("op7_nop_q", bus.q, 16'hAAAA);
        check("op7_nop_depth", bus.depth, 1);

        // POP_REPLACE
        do_reset();
        do_op(0, OP_PUSH, 16'h0005);
        do_op(0, OP_PUSH, 16'h0007);
        check("pr_pre_nos", bus.nos, 16'h0005);
        do_op(0, OP_POP_REPLACE, 16'h000C);
        check("pr_q", bus.q, 16'h000C);
        check("pr_nos", bus.nos, 0);
        check("pr_depth", bus.depth, 1);

        // Underflow on empty ctx1
        do_op(1, OP_POP, 16'h0);
        check("udf_set", bus.udf_err, 1);
        check("udf_depth", bus.depth, 0);
        check("udf_empty", bus.empty, 1);
        check("udf_no_ovf", bus.ovf_err, 0);
`ifdef STACK_GUARD_EN
        check("udf_sp1", dut.sp_reg[1], 8'd0);
`else
        check("udf_sp1", dut.sp_reg[1], 8'd255);
`endif
        check("udf_ctx0_sp", dut.sp_reg[0], 8'd1);
        do_op(1, OP_NOP, 16'h0, 1'b1);
        check("udf_clr", bus.udf_err, 0);
        do_op(1, OP_POP, 16'h0, 1'b1);
        check("udf_set_wins", bus.udf_err, 1);
        do_op(0, OP_NOP, 16'h0, 1'b1);
        check("udf_clr2", bus.udf_err, 0);
        check("ctx0_after_q", bus.q, 16'h000C);

        // Fill ctx0, then overflow
        do_reset();
        for (int i = 1; i <= 255; i++) begin
            do_op(0, OP_PUSH, 16'(i));
        end
        check("fill_full", bus.full, 1);
        check("fill_depth", bus.depth, 255);
        check("fill_q", bus.q, 16'h00FF);
        check("fill_nos", bus.nos, 16'h00FE);
        check("fill_no_ovf", bus.ovf_err, 0);
        do_op(0, OP_PUSH, 16'hDEAD);
        check("ovf_set", bus.ovf_err, 1);
        check("ovf_depth", bus.depth, 255);
        check("ovf_full", bus.full, 1);
`ifdef STACK_GUARD_EN
        check("ovf_q", bus.q, 16'h00FF);
        check("ovf_nos", bus.nos, 16'h00FE);
`else
        check("ovf_q", bus.q, 16'hDEAD);
        check("ovf_nos", bus.nos, 16'h00FF);
`endif

        // Write-first bypass on back-to-back ops
        do_reset();
        do_op(0, OP_PUSH, 16'h1234);
        check("wf_push_q", bus.q, 16'h1234);
        do_op(0, OP_REPLACE, 16'h5678);
        check("wf_repl_q", bus.q, 16'h5678);
        check("wf_repl_depth", bus.depth, 1);
        do_op(0, OP_PUSH, 16'h9ABC);
        check("wf_push2_q", bus.q, 16'h9ABC);
        check("wf_push2_nos", bus.nos, 16'h5678);
        do_op(0, OP_REPLACE, 16'h4321);
        check("wf_repl2_q", bus.q, 16'h4321);
        check("wf_repl2_nos", bus.nos, 16'h5678);
        do_op(0, 3'd5, 16'h0);
        check("op5_nop_q", bus.q, 16'h4321);
        check("op5_nop_depth", bus.depth, 2);
        do_op(1, OP_REPLACE, 16'h7777);
        check("repl_empty_udf", bus.udf_err, 1);
        check("repl_empty_q", bus.q, 0);

        // Asynchronous reset between clock edges
        do_op(0, OP_NOP, 16'h0);
        check("pre_arst_q", bus.q, 16'h4321);
        #2;
        reset = 1'b1;
        #1;
        check("arst_q", bus.q, 0);
        check("arst_nos", bus.nos, 0);
        check("arst_depth", bus.depth, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_udf", bus.udf_err, 0);
        check("arst_sp0", dut.sp_reg[0], 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
